// File: rtl/cte_stream.sv
// cte_stream: packed YUV (4:2:2 / 4:4:4) byte stream to packed RGB pixels.
// A capture FSM assembles {Y,U,V} triples. A two-stage multiply / sum-clamp pipeline
// converts them and feeds a first-word-fall-through output FIFO. Input credit covers
// every in-flight pixel, so the pipeline never needs to stall.
module cte_stream #(
    parameter int unsigned DW         = 8,
    parameter int unsigned FRAC       = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            mode,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3*DW-1:0] out_data,
    output logic            out_clip
);

    localparam int unsigned AW = DW + FRAC + 3;
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned EW = 3 * DW + 1;

    localparam int CrInt  = int'(1.402 * (2.0 ** FRAC));
    localparam int CguInt = int'(0.344 * (2.0 ** FRAC));
    localparam int CgvInt = int'(0.714 * (2.0 ** FRAC));
    localparam int CbInt  = int'(1.772 * (2.0 ** FRAC));

    localparam logic signed [AW-1:0] CoefR   = AW'(CrInt);
    localparam logic signed [AW-1:0] CoefGu  = AW'(CguInt);
    localparam logic signed [AW-1:0] CoefGv  = AW'(CgvInt);
    localparam logic signed [AW-1:0] CoefB   = AW'(CbInt);
    localparam logic signed [AW-1:0] Half    = AW'(2 ** (DW - 1));
    localparam logic signed [AW-1:0] Rnd     = AW'(2 ** (FRAC - 1));
    localparam logic signed [AW-1:0] MaxVal  = AW'(2 ** DW - 1);

    typedef enum logic [1:0] {StU, StY0, StV, StY1} state_e;

    state_e          state_q, state_d;
    logic            mode_q;
    logic [DW-1:0]   u_q, y0_q, v_q;
    logic            rdy_en_q;
    logic            accept;
    logic            issue, cap_u, cap_y0, cap_v;
    logic [DW-1:0]   pix_y, pix_u, pix_v;

    logic signed [AW-1:0] u_s, v_s;
    logic                 s1_valid_q;
    logic [DW-1:0]        s1_y_q;
    logic signed [AW-1:0] s1_rv_q, s1_gu_q, s1_gv_q, s1_bu_q;

    logic signed [AW-1:0] y_sh, acc_r, acc_g, acc_b, sh_r, sh_g, sh_b;
    logic [DW:0]          cl_r, cl_g, cl_b;
    logic                 s2_valid_q;
    logic [3*DW-1:0]      s2_data_q;
    logic                 s2_clip_q;

    logic [EW-1:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic            wr_en, rd_en;
    logic [CW:0]     used;
    logic [EW-1:0]   head;

    // Clamp to [0, 2^DW-1]; MSB of the result flags a clamp event.
    function automatic logic [DW:0] clamp(input logic signed [AW-1:0] x);
        if (x[AW-1]) begin
            return {1'b1, {DW{1'b0}}};
        end else if (x > MaxVal) begin
            return {1'b1, {DW{1'b1}}};
        end
        return {1'b0, x[DW-1:0]};
    endfunction

    // Credit covers FIFO entries plus pixels still in the pipeline.
    assign used     = (CW+1)'(count_q) + (CW+1)'(s1_valid_q) + (CW+1)'(s2_valid_q);
    assign in_ready = rdy_en_q && (used < (CW+1)'(FIFO_DEPTH));
    assign accept   = in_valid && in_ready;

    // Holds in_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rdy_en_q <= 1'b0;
        else        rdy_en_q <= 1'b1;
    end

    // Capture FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= StU;
        else        state_q <= state_d;
    end

    // Next state: advance on accepted bytes only; 4:4:4 skips the Y1 slot.
    always_comb begin
        state_d = state_q;
        if (accept) begin
            unique case (state_q)
                StU:     state_d = StY0;
                StY0:    state_d = StV;
                StV:     state_d = mode_q ? StU : StY1;
                StY1:    state_d = StU;
                default: state_d = StU;
            endcase
        end
    end

    // FSM outputs: capture strobes and the pixel issued this cycle.
    always_comb begin
        issue  = 1'b0;
        cap_u  = 1'b0;
        cap_y0 = 1'b0;
        cap_v  = 1'b0;
        pix_y  = y0_q;
        pix_u  = u_q;
        pix_v  = v_q;
        unique case (state_q)
            StU:  cap_u  = accept;
            StY0: cap_y0 = accept;
            StV: begin
                cap_v = accept;
                issue = accept;
                pix_v = in_data;
            end
            StY1: begin
                issue = accept;
                pix_y = in_data;
            end
            default: ;
        endcase
    end

    // Component capture; mode is latched with U so it only changes per group.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            u_q    <= '0;
            y0_q   <= '0;
            v_q    <= '0;
            mode_q <= 1'b0;
        end else begin
            if (cap_u) begin
                u_q    <= in_data;
                mode_q <= mode;
            end
            if (cap_y0) y0_q <= in_data;
            if (cap_v)  v_q  <= in_data;
        end
    end

    assign u_s = $signed(AW'(pix_u)) - Half;
    assign v_s = $signed(AW'(pix_v)) - Half;

    // Stage 1: register the chroma products.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q <= 1'b0;
            s1_y_q     <= '0;
            s1_rv_q    <= '0;
            s1_gu_q    <= '0;
            s1_gv_q    <= '0;
            s1_bu_q    <= '0;
        end else begin
            s1_valid_q <= issue;
            if (issue) begin
                s1_y_q  <= pix_y;
                s1_rv_q <= CoefR * v_s;
                s1_gu_q <= CoefGu * u_s;
                s1_gv_q <= CoefGv * v_s;
                s1_bu_q <= CoefB * u_s;
            end
        end
    end

    assign y_sh  = $signed(AW'(s1_y_q)) <<< FRAC;
    assign acc_r = y_sh + s1_rv_q + Rnd;
    assign acc_g = y_sh - s1_gu_q - s1_gv_q + Rnd;
    assign acc_b = y_sh + s1_bu_q + Rnd;
    assign sh_r  = acc_r >>> FRAC;
    assign sh_g  = acc_g >>> FRAC;
    assign sh_b  = acc_b >>> FRAC;
    assign cl_r  = clamp(sh_r);
    assign cl_g  = clamp(sh_g);
    assign cl_b  = clamp(sh_b);

    // Stage 2: register the rounded, clamped pixel and its clip flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_clip_q  <= 1'b0;
        end else begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_data_q <= {cl_r[DW-1:0], cl_g[DW-1:0], cl_b[DW-1:0]};
                s2_clip_q <= cl_r[DW] | cl_g[DW] | cl_b[DW];
            end
        end
    end

    assign wr_en     = s2_valid_q;
    assign rd_en     = out_valid && out_ready;
    assign out_valid = (count_q != '0);
    assign head      = mem_q[rd_ptr_q];
    assign out_data  = out_valid ? head[3*DW-1:0] : '0;
    assign out_clip  = out_valid ? head[EW-1] : 1'b0;

    // FIFO storage; contents are only observable through a nonzero count.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= {s2_clip_q, s2_data_q};
    end

    // FIFO occupancy after this cycle's write and read.
    always_comb begin
        count_d = count_q + CW'(wr_en) - CW'(rd_en);
    end

    // FIFO pointers and count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_cte_stream.sv
// Directed bench for cte_stream with default parameters (DW=8, FRAC=8, FIFO_DEPTH=4).
module tb_cte_stream;

    logic        clk;
    logic        reset;
    logic        mode;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_data;
    logic        out_clip;

    logic [24:0] rx_q[$];
    int          n_cmp;
    int          n_fail;
    int          bytes_sent;

    cte_stream #(
        .DW(8),
        .FRAC(8),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .mode(mode),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_clip(out_clip)
    );

    always #5 clk = ~clk;

    // Records each output transfer that will happen at the next rising edge.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) rx_q.push_back({out_clip, out_data});
    end

    // Reference conversion with FRAC=8 integer coefficients.
    function automatic logic [24:0] model_px(input int y, input int u, input int v);
        int   uu;
        int   vv;
        int   ch[3];
        logic clip;
        uu = u - 128;
        vv = v - 128;
        ch[0] = (y * 256 + 359 * vv + 128) >>> 8;
        ch[1] = (y * 256 - 88 * uu - 183 * vv + 128) >>> 8;
        ch[2] = (y * 256 + 454 * uu + 128) >>> 8;
        clip = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (ch[k] < 0) begin
                ch[k] = 0;
                clip = 1'b1;
            end else if (ch[k] > 255) begin
                ch[k] = 255;
                clip = 1'b1;
            end
        end
        return {clip, ch[0][7:0], ch[1][7:0], ch[2][7:0]};
    endfunction

    function automatic logic [24:0] rx_at(input int i);
        if (rx_q.size() > i) return rx_q[i];
        return 25'bx;
    endfunction

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        bit done;
        done = 0;
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                done = 1;
            end
        end
        in_valid = 1'b0;
        if (done) begin
            bytes_sent++;
        end else begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_byte_timeout: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic wait_rx(input int n, output bit ok);
        ok = 0;
        for (int c = 0; c < 3000; c++) begin
            if (rx_q.size() >= n) begin
                ok = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        repeat (6) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready);
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        n_cmp++;
        if (out_data !== 24'h0) begin
            n_fail++; $display("FAIL reset_out_data: got %h want 000000", out_data);
        end
        n_cmp++;
        if (out_clip !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_clip: got %b want 0", out_clip);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL release_in_ready: got %b want 1", in_ready);
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL release_out_valid: got %b want 0", out_valid);
        end
    endtask

    task automatic test_gray_422;
        bit ok;
        rx_q.delete();
        mode = 1'b0;
        send_byte(8'h80);
        send_byte(8'h64);
        send_byte(8'h80);
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL latency_early: out_valid=%b want 0", out_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 24'h646464) begin
            n_fail++;
            $display("FAIL latency_first: out_valid=%b data=%h want 1 646464", out_valid, out_data);
        end
        @(posedge clk);
        #1;
        send_byte(8'hC8);
        wait_rx(2, ok);
        n_cmp++;
        if (!ok || rx_q.size() != 2) begin
            n_fail++; $display("FAIL gray_count: got %0d want 2", rx_q.size());
        end
        n_cmp++;
        if (rx_at(0) !== 25'h0646464) begin
            n_fail++; $display("FAIL gray_px0: got %h want 0646464", rx_at(0));
        end
        n_cmp++;
        if (rx_at(1) !== 25'h0C8C8C8) begin
            n_fail++; $display("FAIL gray_px1: got %h want 0C8C8C8", rx_at(1));
        end
    endtask

    task automatic test_clip_422;
        bit ok;
        rx_q.delete();
        send_byte(8'hFF);
        send_byte(8'hFF);
        send_byte(8'h80);
        send_byte(8'hFF);
        wait_rx(2, ok);
        n_cmp++;
        if (!ok || rx_q.size() != 2) begin
            n_fail++; $display("FAIL clip422_count: got %0d want 2", rx_q.size());
        end
        n_cmp++;
        if (rx_at(0) !== 25'h1FFD3FF) begin
            n_fail++; $display("FAIL clip422_px0: got %h want 1FFD3FF", rx_at(0));
        end
        n_cmp++;
        if (rx_at(1) !== 25'h1FFD3FF) begin
            n_fail++; $display("FAIL clip422_px1: got %h want 1FFD3FF", rx_at(1));
        end
    endtask

    task automatic test_clip_444;
        bit ok;
        rx_q.delete();
        mode = 1'b1;
        send_byte(8'h80);
        send_byte(8'h32);
        send_byte(8'h00);
        mode = 1'b0;
        wait_rx(1, ok);
        n_cmp++;
        if (!ok || rx_q.size() != 1) begin
            n_fail++; $display("FAIL clip444_count: got %0d want 1", rx_q.size());
        end
        n_cmp++;
        if (rx_at(0) !== 25'h1008E32) begin
            n_fail++; $display("FAIL clip444_px: got %h want 1008E32", rx_at(0));
        end
    endtask

    task automatic test_backpressure;
        logic [7:0]  bytes[256];
        logic [24:0] exp_q[$];
        bit          ok;
        rx_q.delete();
        mode       = 1'b0;
        out_ready  = 1'b0;
        bytes_sent = 0;
        for (int g = 0; g < 64; g++) begin
            for (int k = 0; k < 4; k++) bytes[4*g+k] = 8'($urandom_range(0, 255));
            exp_q.push_back(model_px(int'(bytes[4*g+1]), int'(bytes[4*g]), int'(bytes[4*g+2])));
            exp_q.push_back(model_px(int'(bytes[4*g+3]), int'(bytes[4*g]), int'(bytes[4*g+2])));
        end
        fork
            begin
                for (int i = 0; i < 256; i++) send_byte(bytes[i]);
            end
            begin
                repeat (20) @(negedge clk);
                n_cmp++;
                if (in_ready !== 1'b0) begin
                    n_fail++; $display("FAIL bp_in_ready: got %b want 0", in_ready);
                end
                n_cmp++;
                if (bytes_sent != 8) begin
                    n_fail++; $display("FAIL bp_bytes_taken: got %0d want 8", bytes_sent);
                end
                n_cmp++;
                if (out_valid !== 1'b1 || rx_q.size() != 0) begin
                    n_fail++;
                    $display("FAIL bp_stalled: out_valid=%b rx=%0d want 1 0", out_valid, rx_q.size());
                end
                @(posedge clk);
                #1;
                for (int c = 0; c < 3000 && rx_q.size() < 128; c++) begin
                    out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        wait_rx(128, ok);
        n_cmp++;
        if (!ok || rx_q.size() != 128) begin
            n_fail++; $display("FAIL bp_count: got %0d want 128", rx_q.size());
        end
        for (int i = 0; i < 128; i++) begin
            n_cmp++;
            if (rx_at(i) !== exp_q[i]) begin
                n_fail++; $display("FAIL bp_px%0d: got %h want %h", i, rx_at(i), exp_q[i]);
            end
        end
    endtask

    task automatic test_mode_change;
        bit ok;
        rx_q.delete();
        mode = 1'b0;
        send_byte(8'h80);
        send_byte(8'h20);
        mode = 1'b1;
        send_byte(8'h80);
        send_byte(8'h30);
        send_byte(8'h80);
        send_byte(8'h40);
        send_byte(8'h80);
        mode = 1'b0;
        wait_rx(3, ok);
        n_cmp++;
        if (!ok || rx_q.size() != 3) begin
            n_fail++; $display("FAIL mode_count: got %0d want 3", rx_q.size());
        end
        n_cmp++;
        if (rx_at(0) !== 25'h0202020) begin
            n_fail++; $display("FAIL mode_px0: got %h want 0202020", rx_at(0));
        end
        n_cmp++;
        if (rx_at(1) !== 25'h0303030) begin
            n_fail++; $display("FAIL mode_px1: got %h want 0303030", rx_at(1));
        end
        n_cmp++;
        if (rx_at(2) !== 25'h0404040) begin
            n_fail++; $display("FAIL mode_px2: got %h want 0404040", rx_at(2));
        end
    endtask

    task automatic test_reset_midgroup;
        bit ok;
        rx_q.delete();
        mode      = 1'b0;
        out_ready = 1'b0;
        send_byte(8'h80);
        send_byte(8'h20);
        send_byte(8'h80);
        send_byte(8'h30);
        send_byte(8'h80);
        send_byte(8'h50);
        repeat (4) @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1 || dut.count_q !== 3'd2) begin
            n_fail++;
            $display("FAIL rst_pre_fill: out_valid=%b count=%0d want 1 2", out_valid, dut.count_q);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_data !== 24'h0) begin
            n_fail++;
            $display("FAIL rst_async: out_valid=%b in_ready=%b data=%h want 0 0 000000",
                     out_valid, in_ready, out_data);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_held: out_valid=%b in_ready=%b want 0 0", out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        reset     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_q.delete();
        send_byte(8'h80);
        send_byte(8'h10);
        send_byte(8'h80);
        send_byte(8'h10);
        wait_rx(2, ok);
        n_cmp++;
        if (!ok || rx_q.size() != 2) begin
            n_fail++; $display("FAIL rst_after_count: got %0d want 2", rx_q.size());
        end
        n_cmp++;
        if (rx_at(0) !== 25'h0101010) begin
            n_fail++; $display("FAIL rst_after_px0: got %h want 0101010", rx_at(0));
        end
        n_cmp++;
        if (rx_at(1) !== 25'h0101010) begin
            n_fail++; $display("FAIL rst_after_px1: got %h want 0101010", rx_at(1));
        end
    endtask

    initial begin
        clk        = 1'b0;
        reset      = 1'b0;
        mode       = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        out_ready  = 1'b1;
        n_cmp      = 0;
        n_fail     = 0;
        bytes_sent = 0;
        test_reset();
        test_gray_422();
        test_clip_422();
        test_clip_444();
        test_backpressure();
        test_mode_change();
        test_reset_midgroup();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
